// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational adder among R requesters.
// Operands of the winner are registered onto the adder, and the sum is returned with the requester ID.
module adder_share_arbiter #(
  parameter  int N    = 8,
  parameter  int R    = 4,
  localparam int ID_W = $clog2(R)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [R-1:0]    req,
  input  logic [R*N-1:0]  a_in,
  input  logic [R*N-1:0]  b_in,
  input  logic [R-1:0]    cin_in,
  output logic [R-1:0]    grant,
  output logic [N-1:0]    add_a,
  output logic [N-1:0]    add_b,
  output logic            add_cin,
  input  logic [N-1:0]    add_sum,
  input  logic            add_cout,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [N-1:0]    res_sum,
  output logic            res_cout,
  output logic [ID_W-1:0] res_id,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t            state_q, state_d;
  logic [R-1:0]      grant_q, grant_d;
  logic [N-1:0]      add_a_q, add_a_d;
  logic [N-1:0]      add_b_q, add_b_d;
  logic              add_cin_q, add_cin_d;
  logic              res_valid_q, res_valid_d;
  logic [N-1:0]      res_sum_q, res_sum_d;
  logic              res_cout_q, res_cout_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic [ID_W-1:0]   last_ptr_q, last_ptr_d;
  logic              busy_q, busy_d;

  logic [ID_W-1:0]   winner;
  logic              found;
  int unsigned       idx;

  // Search starts just after the last served requester so it drops to lowest priority.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < R; i++) begin
      idx = (int'(last_ptr_q) + 1 + i) % R;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = '0;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_cout_d  = res_cout_q;
    res_id_d    = res_id_q;
    last_ptr_d  = last_ptr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          add_a_d    = a_in[int'(winner)*N +: N];
          add_b_d    = b_in[int'(winner)*N +: N];
          add_cin_d  = cin_in[winner];
          grant_d    = R'(1) << winner;
          res_id_d   = winner;
          last_ptr_d = winner;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        res_sum_d   = add_sum;
        res_cout_d  = add_cout;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Reset discards any in-flight operation and points the search at requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_id_q    <= '0;
      last_ptr_q  <= ID_W'(R - 1);
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
      res_id_q    <= res_id_d;
      last_ptr_q  <= last_ptr_d;
      busy_q      <= busy_d;
    end
  end

  assign grant     = grant_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_id    = res_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: vector table plus round-robin, backpressure,
// mid-operation reset and pointer-wrap sequences against a behavioural shared adder.
module tb_adder_share_arbiter;

  localparam int N    = 8;
  localparam int R    = 4;
  localparam int ID_W = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [R-1:0]    req;
  logic [R*N-1:0]  a_in;
  logic [R*N-1:0]  b_in;
  logic [R-1:0]    cin_in;
  logic [R-1:0]    grant;
  logic [N-1:0]    add_a;
  logic [N-1:0]    add_b;
  logic            add_cin;
  logic [N-1:0]    add_sum;
  logic            add_cout;
  logic            res_valid;
  logic            res_ready;
  logic [N-1:0]    res_sum;
  logic            res_cout;
  logic [ID_W-1:0] res_id;
  logic            busy;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] expSum;
    logic       expCout;
  } vec_t;

  vec_t vecs[6];

  adder_share_arbiter #(.N(N), .R(R)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .grant(grant), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id), .busy(busy)
  );

  // The external shared adder the arbiter drives.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [R-1:0] r, input int id, input logic [7:0] a,
                               input logic [7:0] b, input logic c);
    a_in[id*N +: N] = a;
    b_in[id*N +: N] = b;
    cin_in[id]      = c;
    req             = r;
  endtask

  task automatic waitGrant(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (grant == '0 && cyc < 20);
    if (grant == '0) checkOutput("grant_timeout", 32'(grant), 32'hF);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int cyc;
    int gCount;
    int lastCyc;
    logic [R-1:0] expGrant;

    vecs[0] = '{1, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[1] = '{0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1};
    vecs[2] = '{2, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[3] = '{3, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    vecs[4] = '{0, 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{2, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

    req       = '0;
    a_in      = '0;
    b_in      = '0;
    cin_in    = '0;
    res_ready = 1'b1;
    tick();
    tick();
    checkOutput("rst_grant", 32'(grant), 0);
    checkOutput("rst_valid", 32'(res_valid), 0);
    checkOutput("rst_sum", 32'(res_sum), 0);
    checkOutput("rst_cout", 32'(res_cout), 0);
    checkOutput("rst_id", 32'(res_id), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_ops", 32'({add_a, add_b, add_cin}), 0);
    rst_n = 1'b1;

    // Single-requester vectors; other slots hold decoy operands.
    for (int i = 0; i < 6; i++) begin
      a_in   = {R{8'h5A}};
      b_in   = {R{8'hC3}};
      cin_in = '1;
      applyStimulus(R'(1) << vecs[i].id, vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin);
      waitGrant(cyc);
      checkOutput("vec_latency", 32'(cyc), 1);
      checkOutput("vec_grant", 32'(grant), 32'(R'(1) << vecs[i].id));
      checkOutput("vec_add_a", 32'(add_a), 32'(vecs[i].a));
      req = '0;
      tick();
      checkOutput("vec_grant_pulse", 32'(grant), 0);
      checkOutput("vec_valid", 32'(res_valid), 1);
      checkOutput("vec_sum", 32'(res_sum), 32'(vecs[i].expSum));
      checkOutput("vec_cout", 32'(res_cout), 32'(vecs[i].expCout));
      checkOutput("vec_id", 32'(res_id), 32'(vecs[i].id));
      checkOutput("vec_busy", 32'(busy), 1);
      tick();
      checkOutput("vec_valid_drop", 32'(res_valid), 0);
      checkOutput("vec_idle", 32'(busy), 0);
    end

    // Round-robin with all requesters held high from reset.
    doReset();
    req     = '1;
    gCount  = 0;
    lastCyc = 0;
    for (int c = 1; c <= 30 && gCount < 5; c++) begin
      tick();
      if (grant != '0) begin
        expGrant = R'(1) << (gCount % R);
        checkOutput("rr_grant", 32'(grant), 32'(expGrant));
        checkOutput("rr_gap", 32'(c - lastCyc), gCount == 0 ? 1 : 3);
        lastCyc = c;
        gCount++;
      end
    end
    checkOutput("rr_count", 32'(gCount), 5);
    req = '0;
    tick();
    tick();

    // Backpressure with requester 2 pending behind a held result.
    doReset();
    res_ready = 1'b0;
    applyStimulus(4'b0001, 0, 8'h10, 8'h20, 1'b0);
    applyStimulus(4'b0001, 2, 8'h03, 8'h04, 1'b1);
    waitGrant(cyc);
    checkOutput("bp_grant0", 32'(grant), 32'h1);
    req = 4'b0100;
    tick();
    for (int k = 0; k < 10; k++) begin
      checkOutput("bp_valid", 32'(res_valid), 1);
      checkOutput("bp_sum", 32'(res_sum), 32'h30);
      checkOutput("bp_id", 32'(res_id), 0);
      checkOutput("bp_no_grant", 32'(grant), 0);
      checkOutput("bp_busy", 32'(busy), 1);
      tick();
    end
    res_ready = 1'b1;
    tick();
    checkOutput("bp_release", 32'(res_valid), 0);
    tick();
    checkOutput("bp_grant2", 32'(grant), 32'h4);
    req = '0;
    tick();
    checkOutput("bp_sum2", 32'({res_cout, res_sum}), 32'h008);
    checkOutput("bp_id2", 32'(res_id), 2);
    tick();

    // Asynchronous reset while in ISSUE.
    applyStimulus(4'b0010, 1, 8'h11, 8'h22, 1'b0);
    waitGrant(cyc);
    checkOutput("mr_grant1", 32'(grant), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mr_grant_clr", 32'(grant), 0);
    checkOutput("mr_valid_clr", 32'(res_valid), 0);
    checkOutput("mr_busy_clr", 32'(busy), 0);
    req = 4'b1000;
    tick();
    #2 rst_n = 1'b1;
    waitGrant(cyc);
    checkOutput("mr_latency", 32'(cyc), 1);
    checkOutput("mr_grant3", 32'(grant), 32'h8);
    req = '0;
    tick();
    checkOutput("mr_id", 32'(res_id), 3);
    tick();

    // Pointer wrap after requester 3 was served.
    req = 4'b1001;
    waitGrant(cyc);
    checkOutput("wrap_first", 32'(grant), 32'h1);
    waitGrant(cyc);
    checkOutput("wrap_gap", 32'(cyc), 3);
    checkOutput("wrap_second", 32'(grant), 32'h8);
    req = '0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
